// File: rtl/motor_cmd_arbiter_pkg.sv
// Shared encodings for the motor command arbiter: modes, source codes,
// FSM states, and the per-channel slew step helper.
package motor_cmd_arbiter_pkg;

   localparam logic [7:0] MODE_OFF = 8'd0;
   localparam logic [7:0] MODE_RC  = 8'd1;
   localparam logic [7:0] MODE_AI  = 8'd2;

   localparam logic [1:0] SRC_NONE = 2'd0;
   localparam logic [1:0] SRC_RC   = 2'd1;
   localparam logic [1:0] SRC_AI   = 2'd2;
   localparam logic [1:0] SRC_SAFE = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_BACKOFF = 2'd2,
      ST_STALE   = 2'd3
   } state_t;

   // Move cur toward tgt by at most step. The 9-bit difference cannot
   // overflow, and the result always lies between cur and tgt, so it fits
   // back into 8 bits without wrapping.
   function automatic logic signed [7:0] slew_step(input logic signed [7:0] cur,
                                                   input logic signed [7:0] tgt,
                                                   input logic [7:0]        step);
      logic signed [8:0] diff;
      logic signed [8:0] lim;
      logic signed [8:0] nxt;
      diff = tgt - cur;
      lim  = $signed({1'b0, step});
      if (diff > lim) begin
         diff = lim;
      end else if (diff < -lim) begin
         diff = -lim;
      end
      nxt = cur + diff;
      return nxt[7:0];
   endfunction

endpackage

// File: rtl/motor_slew.sv
// One slew-limited speed channel: steps toward the target on each enable,
// or clears immediately when zero is asserted.
module motor_slew
   import motor_cmd_arbiter_pkg::*;
#(
   parameter logic [7:0] STEP = 8'd4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              zero,
   input  logic signed [7:0] target,
   output logic signed [7:0] out
);

   logic signed [7:0] out_q;
   logic signed [7:0] out_d;

   // Next output: forced zero wins over a slew step.
   always_comb begin
      out_d = out_q;
      if (zero) begin
         out_d = '0;
      end else if (en) begin
         out_d = slew_step(out_q, target, STEP);
      end
   end

   // Output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q <= '0;
      end else begin
         out_q <= out_d;
      end
   end

   assign out = out_q;

endmodule

// File: rtl/motor_cmd_arbiter.sv
// Motor command arbiter: selects RC, AI or safety back-off, slew-limits the
// chosen speed pair, runs the command watchdog and drives the alive strobe.
module motor_cmd_arbiter
   import motor_cmd_arbiter_pkg::*;
#(
   parameter logic [15:0] SLEW_DIV       = 16'd14746,
   parameter logic [7:0]  STEP           = 8'd4,
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd7372800,
   parameter logic [23:0] BACKOFF_CYCLES = 24'd8388607,
   parameter logic [7:0]  BACKOFF_SPEED  = 8'd44
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        mode,
   input  logic signed [7:0] rc_speed_a,
   input  logic signed [7:0] rc_speed_b,
   input  logic              rc_tick,
   input  logic signed [7:0] ai_speed_a,
   input  logic signed [7:0] ai_speed_b,
   input  logic              ai_tick,
   input  logic              bump_left,
   input  logic              bump_right,
   output logic signed [7:0] speed_a,
   output logic signed [7:0] speed_b,
   output logic              alive_strobe,
   output logic [1:0]        source,
   output logic              timeout
);

   localparam logic signed [7:0] BO_TGT = signed'(8'd0 - BACKOFF_SPEED);

   logic [2:0]        rc_sync_q, ai_sync_q;
   logic [1:0]        bl_sync_q, br_sync_q;
   logic              bump_prev_q;
   logic [15:0]       pre_q;
   state_t            state_q, state_d;
   logic signed [7:0] tgt_a_q, tgt_a_d, tgt_b_q, tgt_b_d;
   logic [23:0]       wd_q, wd_d, bo_q, bo_d;
   logic              timeout_q, timeout_d, strobe_q, strobe_d;
   logic [1:0]        sel_q, sel_d;
   logic              rc_ev, ai_ev, bump_any, bump_rise, slew_tick, mode_off;
   logic              sel_tick;
   logic signed [7:0] sel_a, sel_b;
   logic [1:0]        mode_src;

   assign rc_ev     = rc_sync_q[2] ^ rc_sync_q[1];
   assign ai_ev     = ai_sync_q[2] ^ ai_sync_q[1];
   assign bump_any  = bl_sync_q[1] | br_sync_q[1];
   assign bump_rise = bump_any & ~bump_prev_q;
   assign slew_tick = (pre_q == SLEW_DIV - 16'd1);
   assign mode_src  = mode[1:0];
   assign sel_tick  = (sel_q == SRC_RC) ? rc_ev : ai_ev;
   assign sel_a     = (sel_q == SRC_RC) ? rc_speed_a : ai_speed_a;
   assign sel_b     = (sel_q == SRC_RC) ? rc_speed_b : ai_speed_b;

   // Decode mode: anything other than RC or AI counts as OFF.
   always_comb begin
      case (mode)
         MODE_RC, MODE_AI: mode_off = 1'b0;
         MODE_OFF:         mode_off = 1'b1;
         default:          mode_off = 1'b1;
      endcase
   end

   // Two-FF synchronisers, plus a third stage on the toggles for edge detect.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rc_sync_q   <= '0;
         ai_sync_q   <= '0;
         bl_sync_q   <= '0;
         br_sync_q   <= '0;
         bump_prev_q <= 1'b0;
      end else begin
         rc_sync_q   <= {rc_sync_q[1:0], rc_tick};
         ai_sync_q   <= {ai_sync_q[1:0], ai_tick};
         bl_sync_q   <= {bl_sync_q[0], bump_left};
         br_sync_q   <= {br_sync_q[0], bump_right};
         bump_prev_q <= bump_any;
      end
   end

   // Free-running slew prescaler.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q <= '0;
      end else begin
         pre_q <= slew_tick ? 16'd0 : pre_q + 16'd1;
      end
   end

   // Next-state logic; OFF overrides bumps and ticks in the same cycle.
   always_comb begin
      state_d   = state_q;
      tgt_a_d   = tgt_a_q;
      tgt_b_d   = tgt_b_q;
      wd_d      = wd_q;
      bo_d      = bo_q;
      timeout_d = timeout_q;
      sel_d     = sel_q;
      if (mode_off) begin
         state_d   = ST_IDLE;
         tgt_a_d   = '0;
         tgt_b_d   = '0;
         wd_d      = '0;
         bo_d      = '0;
         timeout_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               sel_d     = mode_src;
               tgt_a_d   = '0;
               tgt_b_d   = '0;
               wd_d      = '0;
               bo_d      = '0;
               timeout_d = 1'b0;
               if (bump_any) begin
                  state_d = ST_BACKOFF;
                  tgt_a_d = BO_TGT;
                  tgt_b_d = BO_TGT;
               end else begin
                  state_d = ST_RUN;
               end
            end
            ST_BACKOFF: begin
               sel_d = mode_src;
               if (bump_any) begin
                  bo_d = '0;
               end else if (bo_q + 24'd1 == BACKOFF_CYCLES) begin
                  state_d = ST_RUN;
                  tgt_a_d = '0;
                  tgt_b_d = '0;
                  wd_d    = '0;
                  bo_d    = '0;
               end else begin
                  bo_d = bo_q + 24'd1;
               end
            end
            default: begin
               if (bump_rise) begin
                  state_d   = ST_BACKOFF;
                  tgt_a_d   = BO_TGT;
                  tgt_b_d   = BO_TGT;
                  timeout_d = 1'b0;
                  bo_d      = '0;
                  wd_d      = '0;
               end else if (mode_src != sel_q) begin
                  state_d   = ST_RUN;
                  sel_d     = mode_src;
                  tgt_a_d   = '0;
                  tgt_b_d   = '0;
                  wd_d      = '0;
                  timeout_d = 1'b0;
               end else if (sel_tick) begin
                  state_d   = ST_RUN;
                  tgt_a_d   = sel_a;
                  tgt_b_d   = sel_b;
                  wd_d      = '0;
                  timeout_d = 1'b0;
               end else if (state_q == ST_RUN) begin
                  wd_d = wd_q + 24'd1;
                  if (wd_q + 24'd1 == TIMEOUT_CYCLES) begin
                     state_d   = ST_STALE;
                     timeout_d = 1'b1;
                     tgt_a_d   = '0;
                     tgt_b_d   = '0;
                  end
               end
            end
         endcase
      end
   end

   // Alive strobe toggles per slew tick while actively driving.
   always_comb begin
      strobe_d = strobe_q;
      if (slew_tick && ((state_q == ST_RUN) || (state_q == ST_BACKOFF) ||
                        ((state_q == ST_STALE) && ((speed_a != 8'sd0) || (speed_b != 8'sd0))))) begin
         strobe_d = ~strobe_q;
      end
   end

   // Control and target registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         tgt_a_q   <= '0;
         tgt_b_q   <= '0;
         wd_q      <= '0;
         bo_q      <= '0;
         timeout_q <= 1'b0;
         sel_q     <= SRC_NONE;
         strobe_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         tgt_a_q   <= tgt_a_d;
         tgt_b_q   <= tgt_b_d;
         wd_q      <= wd_d;
         bo_q      <= bo_d;
         timeout_q <= timeout_d;
         sel_q     <= sel_d;
         strobe_q  <= strobe_d;
      end
   end

   // Reported source follows the state.
   always_comb begin
      case (state_q)
         ST_IDLE:    source = SRC_NONE;
         ST_BACKOFF: source = SRC_SAFE;
         default:    source = sel_q;
      endcase
   end

   motor_slew #(.STEP(STEP)) u_slew_a (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (slew_tick && (state_q != ST_IDLE)),
      .zero   (state_d == ST_IDLE),
      .target (tgt_a_q),
      .out    (speed_a)
   );

   motor_slew #(.STEP(STEP)) u_slew_b (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (slew_tick && (state_q != ST_IDLE)),
      .zero   (state_d == ST_IDLE),
      .target (tgt_b_q),
      .out    (speed_b)
   );

   assign alive_strobe = strobe_q;
   assign timeout      = timeout_q;

endmodule

// File: tb/tb_motor_cmd_arbiter.sv
// Scoreboard bench for motor_cmd_arbiter with shortened timing parameters.
module tb_motor_cmd_arbiter;

   logic              clk;
   logic              rst_n;
   logic [7:0]        mode;
   logic signed [7:0] rc_speed_a, rc_speed_b, ai_speed_a, ai_speed_b;
   logic              rc_tick, ai_tick, bump_left, bump_right;
   logic signed [7:0] speed_a, speed_b;
   logic              alive_strobe, timeout;
   logic [1:0]        source;

   int checks = 0;
   int errors = 0;
   int qa[$];
   int qb[$];
   logic signed [7:0] prev_a = 0;
   logic signed [7:0] prev_b = 0;
   logic              prev_strobe = 0;
   int                strobe_cnt = 0;
   bit                mon_en = 1;

   motor_cmd_arbiter #(
      .SLEW_DIV       (16'd4),
      .STEP           (8'd4),
      .TIMEOUT_CYCLES (24'd64),
      .BACKOFF_CYCLES (24'd32),
      .BACKOFF_SPEED  (8'd44)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .mode         (mode),
      .rc_speed_a   (rc_speed_a),
      .rc_speed_b   (rc_speed_b),
      .rc_tick      (rc_tick),
      .ai_speed_a   (ai_speed_a),
      .ai_speed_b   (ai_speed_b),
      .ai_tick      (ai_tick),
      .bump_left    (bump_left),
      .bump_right   (bump_right),
      .speed_a      (speed_a),
      .speed_b      (speed_b),
      .alive_strobe (alive_strobe),
      .source       (source),
      .timeout      (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Expected output trajectory: each slew tick moves at most 4 toward the target.
   task automatic push_ramp(input bit ch, input int from, input int to);
      int cur;
      int d;
      cur = from;
      while (cur != to) begin
         d = to - cur;
         if (d > 4) d = 4;
         if (d < -4) d = -4;
         cur = cur + d;
         if (ch) qb.push_back(cur);
         else qa.push_back(cur);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic rc_send(input int a, input int b);
      rc_speed_a = 8'(a);
      rc_speed_b = 8'(b);
      rc_tick    = ~rc_tick;
   endtask

   task automatic ai_send(input int a, input int b);
      ai_speed_a = 8'(a);
      ai_speed_b = 8'(b);
      ai_tick    = ~ai_tick;
   endtask

   // Wait n cycles, refreshing the RC watchdog with the current data.
   task automatic hold_rc(input int n);
      for (int i = 0; i < n; i++) begin
         if (i % 32 == 31) rc_tick = ~rc_tick;
         wait_clk(1);
      end
   endtask

   // Output monitor: every change of a speed must match the next expected value.
   always @(negedge clk) begin
      if (mon_en) begin
         if (speed_a !== prev_a) begin
            if (qa.size() == 0) chk("spd_a_unexpected", speed_a, prev_a);
            else chk("spd_a_step", speed_a, qa.pop_front());
         end
         if (speed_b !== prev_b) begin
            if (qb.size() == 0) chk("spd_b_unexpected", speed_b, prev_b);
            else chk("spd_b_step", speed_b, qb.pop_front());
         end
      end
      prev_a = speed_a;
      prev_b = speed_b;
      if (alive_strobe !== prev_strobe) strobe_cnt++;
      prev_strobe = alive_strobe;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got %0d expected %0d", checks, -1);
      $fatal(1, "bench did not complete");
   end

   initial begin
      rst_n = 1'b0; mode = 8'd0;
      rc_speed_a = 0; rc_speed_b = 0; rc_tick = 0;
      ai_speed_a = 0; ai_speed_b = 0; ai_tick = 0;
      bump_left = 0; bump_right = 0;
      #12;
      chk("rst_speed_a", speed_a, 0);
      chk("rst_speed_b", speed_b, 0);
      chk("rst_source", source, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_strobe", alive_strobe, 0);
      wait_clk(3);
      rst_n = 1'b1;
      wait_clk(5);
      chk("idle_source", source, 0);

      // RC ramp 0 -> (40, -8), strobe every slew tick
      mode = 8'd1;
      wait_clk(2);
      chk("run_source_rc", source, 1);
      push_ramp(0, 0, 40);
      push_ramp(1, 0, -8);
      rc_send(40, -8);
      strobe_cnt = 0;
      wait_clk(40);
      chk("strobe_10_ticks", strobe_cnt, 10);
      wait_clk(8);
      chk("ramp_a_40", speed_a, 40);
      chk("ramp_b_m8", speed_b, -8);

      // Full-scale swing without wrap, and a small target landing exactly
      push_ramp(0, 40, 127);
      push_ramp(1, -8, 0);
      rc_send(127, 0);
      hold_rc(100);
      chk("ramp_a_127", speed_a, 127);
      push_ramp(0, 127, -128);
      push_ramp(1, 0, 2);
      rc_send(-128, 2);
      hold_rc(270);
      chk("ramp_a_m128", speed_a, -128);
      chk("ramp_b_2", speed_b, 2);

      // Watchdog expiry, ramp down, strobe stops, recovery on next tick
      push_ramp(0, -128, 40);
      rc_send(40, 2);
      hold_rc(180);
      chk("wd_pre_a_40", speed_a, 40);
      rc_send(40, 2);
      wait_clk(40);
      chk("wd_not_yet", timeout, 0);
      push_ramp(0, 40, 0);
      push_ramp(1, 2, 0);
      wait_clk(40);
      chk("wd_timeout", timeout, 1);
      chk("wd_source", source, 1);
      wait_clk(50);
      chk("stale_a_0", speed_a, 0);
      chk("stale_b_0", speed_b, 0);
      strobe_cnt = 0;
      wait_clk(40);
      chk("stale_strobe_held", strobe_cnt, 0);
      chk("stale_timeout_held", timeout, 1);
      push_ramp(0, 0, 12);
      push_ramp(1, 0, -12);
      rc_send(12, -12);
      wait_clk(5);
      chk("recover_timeout", timeout, 0);
      wait_clk(20);
      chk("recover_a", speed_a, 12);
      chk("recover_b", speed_b, -12);
      chk("recover_strobe", (strobe_cnt != 0), 1);

      // Switch to AI, then bump back-off
      push_ramp(0, 12, 0);
      push_ramp(1, -12, 0);
      mode = 8'd2;
      wait_clk(2);
      chk("ai_source", source, 2);
      wait_clk(20);
      chk("ai_switch_a_0", speed_a, 0);
      push_ramp(0, 0, 44);
      push_ramp(1, 0, 44);
      ai_send(44, 44);
      wait_clk(50);
      chk("ai_a_44", speed_a, 44);
      chk("ai_b_44", speed_b, 44);
      push_ramp(0, 44, -44);
      push_ramp(1, 44, -44);
      bump_left = 1'b1;
      wait_clk(4);
      chk("bo_source", source, 3);
      chk("bo_timeout", timeout, 0);
      wait_clk(46);
      ai_send(20, 20);
      wait_clk(50);
      chk("bo_a_m44", speed_a, -44);
      chk("bo_b_m44", speed_b, -44);
      bump_left = 1'b0;
      push_ramp(0, -44, 0);
      push_ramp(1, -44, 0);
      wait_clk(25);
      chk("bo_hold_source", source, 3);
      wait_clk(20);
      chk("bo_exit_source", source, 2);
      chk("bo_exit_timeout", timeout, 0);
      wait_clk(60);
      chk("bo_exit_a_0", speed_a, 0);
      push_ramp(0, 0, 44);
      push_ramp(1, 0, 44);
      ai_send(44, 44);
      wait_clk(50);
      chk("ai2_a_44", speed_a, 44);

      // OFF together with a bump: immediate zero, no back-off
      qa.push_back(0);
      qb.push_back(0);
      mode = 8'd0;
      bump_right = 1'b1;
      wait_clk(1);
      chk("off_a_0", speed_a, 0);
      chk("off_b_0", speed_b, 0);
      chk("off_source", source, 0);
      wait_clk(10);
      chk("off_no_backoff", source, 0);
      bump_right = 1'b0;
      wait_clk(5);

      // Asynchronous reset mid-ramp
      mode = 8'd1;
      wait_clk(3);
      chk("f_source_rc", source, 1);
      mon_en = 0;
      rc_send(100, -100);
      wait_clk(20);
      chk("f_moving", (speed_a != 0), 1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_a", speed_a, 0);
      chk("arst_b", speed_b, 0);
      chk("arst_source", source, 0);
      chk("arst_timeout", timeout, 0);
      mode = 8'd0;
      wait_clk(2);
      rst_n = 1'b1;
      wait_clk(10);
      mon_en = 1;
      chk("post_rst_idle", source, 0);
      chk("post_rst_a", speed_a, 0);
      mode = 8'd1;
      wait_clk(3);
      chk("post_rst_run", source, 1);

      chk("qa_drained", qa.size(), 0);
      chk("qb_drained", qb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
